stream_dot_acc: RTL and testbench
=================================

// Module: stream_dot_acc
// PURPOSE
//  Downstream consumer of the left/right join stage: takes joined {a,b} operand beats,
//  multiplies each pair (signed), accumulates K_LEN consecutive products, emits one dot
//  product per group on a valid/ready stream. Forms the MAC element of the GEMM datapath.
// PARAMETERS
//  A_WIDTH    8   width of signed operand a (upper field of i_data)
//  B_WIDTH    8   width of signed operand b (lower field of i_data)
//  ACC_WIDTH  32  accumulator/result width; must be >= A_WIDTH+B_WIDTH (elab-time check)
//  K_LEN      4   beats per dot product; >= 1
// PORTS
//  clk      in   1                  clock, all state on rising edge
//  reset_n  in   1                  asynchronous, active-low reset
//  i_valid  in   1                  operand beat valid
//  i_ready  out  1                  operand beat accepted when i_valid && i_ready
//  i_data   in   A_WIDTH+B_WIDTH    {a, b}; a in MSBs, b in LSBs
//  o_valid  out  1                  dot product valid
//  o_ready  in   1                  downstream accepts when o_valid && o_ready
//  o_data   out  ACC_WIDTH          signed dot product
//  o_count  out  $clog2(K_LEN+1)    beats accepted into the group in progress (debug)
// BEHAVIOUR
//  - Reset (reset_n low, async): o_valid=0, o_data=0, o_count=0, product stage empty,
//    accumulator=0, beat counter=0. i_ready=1 after release. Partial group is discarded.
//  - Global advance enable: en = !o_valid || o_ready. i_ready = en (combinational
//    o_ready->i_ready path is intended). All stages update only when en.
//  - Stage 1 (product): on accept, p <= signed(a)*signed(b) (A+B bits), p_valid<=1,
//    p_last <= (cnt == K_LEN-1). Beat counter cnt increments, wraps K_LEN-1 -> 0.
//    On en without accept: p_valid<=0.
//  - Stage 2 (accumulate): when en && p_valid: sum = acc + sext(p) mod 2^ACC_WIDTH.
//    If p_last: o_data<=sum, o_valid<=1, acc<=0. Else acc<=sum.
//    When en and no p_last write: o_valid<=0 (o_data holds last value).
//  - Latency: last beat of a group accepted cycle t -> o_valid=1 at t+2. Throughput one
//    beat/cycle with o_ready=1; one result per K_LEN beats.
//  - Stall: o_valid && !o_ready freezes o_data, o_valid, p, acc, cnt; i_ready=0.
//  - Simultaneous: result taken (o_ready) in same cycle next result completes -> o_data
//    replaced, o_valid stays 1, no bubble.
//  - K_LEN=1: every beat is last; acc unused (always 0); output = sext(a*b).
//  - Overflow: accumulator wraps silently two's complement; no saturation, no flag.
//  - Input gaps (i_valid=0) do not close a group; groups are defined by beat count only.
//  - o_count = cnt (0..K_LEN-1).
// STRUCTURE
//  - gemm_pkg: sext helper function, default operand/acc width constants shared with the
//    join stage and later array stages.
//  - No sub-module required; the multiply is an inline registered stage so synthesis can
//    map it to a DSP. Single always_ff per stage, async reset on all flops.
// TESTING (K_LEN=4, A/B=8, ACC=32 unless stated)
//  1. (1,2),(3,4),(5,6),(7,8) back-to-back, o_ready=1 -> o_data=100, o_valid one cycle,
//     asserted exactly 2 cycles after 4th accept.
//  2. (-128,-128)x4 -> 65536; then (-1,1)x4 -> 0xFFFFFFFC (-4); two results, no bubble.
//  3. Result pending, o_ready=0 for 5 cycles -> o_data stable, o_valid=1, i_ready=0, no
//     beats accepted; release -> next group (1,1)x4 yields 4.
//  4. i_valid toggled every other cycle with group of test 1 -> o_data=100, o_count steps
//     0,1,2,3,0 only on accepts.
//  5. Two beats (9,9) accepted, reset_n low mid-group -> o_valid=0, o_count=0 immediately;
//     after release (1,1)x4 -> 4 (no residue of 162).
//  6. ACC_WIDTH=16: (-128,-128)x4 -> 0x0000 (wrap); (127,127)x4 -> 64516 (0xFC04).
//  Formal: stall-stability of o_data/o_valid, o_valid low after reset, result count ==
//  accepted beats / K_LEN.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared GEMM datapath constants and helpers.
// Used by the join stage, MAC elements and array stages.
package gemm_pkg;

  localparam int GEMM_A_WIDTH   = 8;
  localparam int GEMM_B_WIDTH   = 8;
  localparam int GEMM_ACC_WIDTH = 32;
  localparam int GEMM_K_LEN     = 4;
  localparam int GEMM_MAX_WIDTH = 64;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] s;
    s = v << (64 - w);
    return $unsigned($signed(s) >>> (64 - w));
  endfunction

endpackage

// File: rtl/stream_dot_acc.sv
// Streaming signed dot product: K_LEN {a,b} beats in,
// one accumulated result out on a valid/ready stream.
// Ports: clk, reset_n (async low),
//   i_valid/i_ready/i_data = {a,b} operand beats,
//   o_valid/o_ready/o_data = dot product,
//   o_count = beats taken into the open group.
module stream_dot_acc
  import gemm_pkg::*;
#(
  parameter int A_WIDTH   = GEMM_A_WIDTH,
  parameter int B_WIDTH   = GEMM_B_WIDTH,
  parameter int ACC_WIDTH = GEMM_ACC_WIDTH,
  parameter int K_LEN     = GEMM_K_LEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [A_WIDTH+B_WIDTH-1:0]   i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [ACC_WIDTH-1:0]         o_data,
  output logic [$clog2(K_LEN+1)-1:0]   o_count
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(K_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(K_LEN - 1);

  if (ACC_WIDTH < PW || ACC_WIDTH > GEMM_MAX_WIDTH)
  begin : g_bad_acc
    $error("stream_dot_acc: bad ACC_WIDTH");
  end

  if (K_LEN < 1) begin : g_bad_k
    $error("stream_dot_acc: K_LEN < 1");
  end

  logic                        en;
  logic                        take;
  logic signed [A_WIDTH-1:0]   a;
  logic signed [B_WIDTH-1:0]   b;
  logic signed [PW-1:0]        p;
  logic                        p_valid;
  logic                        p_last;
  logic [CW-1:0]               cnt;
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH-1:0]        sum;

  // Whole pipe moves together; a held result
  // back-pressures straight through to i_ready.
  assign en      = !o_valid || o_ready;
  assign i_ready = en;
  assign take    = i_valid && en;

  assign a = i_data[PW-1 -: A_WIDTH];
  assign b = i_data[B_WIDTH-1:0];

  assign sum = acc
             + ACC_WIDTH'(sext(64'($unsigned(p)), PW));

  assign o_count = cnt;

  // Product stage, kept as its own register for DSP mapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      cnt     <= '0;
    end else if (en) begin
      p_valid <= take;
      if (take) begin
        p      <= PW'(a) * PW'(b);
        p_last <= (cnt == LAST);
        cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  // Accumulate stage; the last product of a group
  // goes straight to the output and clears acc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (en) begin
      if (p_valid && p_last) begin
        o_data  <= sum;
        o_valid <= 1'b1;
        acc     <= '0;
      end else begin
        o_valid <= 1'b0;
        if (p_valid) begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_dot_acc.sv
// Directed bench for stream_dot_acc with a result
// scoreboard; second instance covers a 16-bit accumulator.
module tb_stream_dot_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [2:0]  o_count;

  logic        v2;
  logic        ir2;
  logic [15:0] d2;
  logic        ov2;
  logic        or2;
  logic [15:0] od2;
  logic [2:0]  oc2;

  int checks   = 0;
  int failures = 0;
  int results  = 0;
  logic [31:0] sb[$];

  stream_dot_acc #(
    .A_WIDTH(8), .B_WIDTH(8),
    .ACC_WIDTH(32), .K_LEN(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_count(o_count)
  );

  stream_dot_acc #(
    .A_WIDTH(8), .B_WIDTH(8),
    .ACC_WIDTH(16), .K_LEN(4)
  ) dut16 (
    .clk(clk), .reset_n(reset_n),
    .i_valid(v2), .i_ready(ir2),
    .i_data(d2),
    .o_valid(ov2), .o_ready(or2),
    .o_data(od2), .o_count(oc2)
  );

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard: compare on each handshake.
  always @(negedge clk) begin
    if (reset_n && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        chk("result_expected", 64'(0), 64'(1));
      end else begin
        chk("result", 64'(o_data),
            64'(sb.pop_front()));
        results++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input int a, input int b);
    bit ok;
    ok = 1'b0;
    i_valid = 1'b1;
    i_data  = {8'(a), 8'(b)};
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = i_ready;
      tick();
    end
    if (!ok) chk("beat_timeout", 64'(0), 64'(1));
  endtask

  int ta[4] = '{1, 3, 5, 7};
  int tb[4] = '{2, 4, 6, 8};

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b1;
    v2      = 1'b0;
    d2      = '0;
    or2     = 1'b1;

    #3;
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_data", 64'(o_data), 64'(0));
    chk("rst_o_count", 64'(o_count), 64'(0));
    #9 reset_n = 1'b1;
    tick();
    chk("rst_i_ready", 64'(i_ready), 64'(1));

    // Test 1: basic group and latency
    beat(1, 2);
    beat(3, 4);
    beat(5, 6);
    sb.push_back(32'd100);
    beat(7, 8);
    i_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat_early", 64'(o_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_lat_valid", 64'(o_valid), 64'(1));
    chk("t1_data", 64'(o_data), 64'(100));
    tick();
    @(negedge clk);
    chk("t1_one_cycle", 64'(o_valid), 64'(0));
    tick();

    // Test 4: gapped input, count only on accepts
    chk("t4_cnt0", 64'(o_count), 64'(0));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(32'd100);
      beat(ta[i], tb[i]);
      i_valid = 1'b0;
      chk("t4_cnt_acc", 64'(o_count),
          64'((i + 1) % 4));
      tick();
      chk("t4_cnt_gap", 64'(o_count),
          64'((i + 1) % 4));
    end
    idle(3);

    // Test 2: extremes, negative result
    sb.push_back(32'd65536);
    repeat (4) beat(-128, -128);
    sb.push_back(32'hFFFF_FFFC);
    repeat (4) beat(-1, 1);
    idle(3);

    // Test 3: stall with a pending result
    o_ready = 1'b0;
    sb.push_back(32'd24);
    repeat (4) beat(2, 3);
    idle(2);
    i_valid = 1'b1;
    i_data  = {8'd1, 8'd1};
    repeat (5) begin
      @(negedge clk);
      chk("t3_valid", 64'(o_valid), 64'(1));
      chk("t3_data", 64'(o_data), 64'(24));
      chk("t3_i_ready", 64'(i_ready), 64'(0));
      chk("t3_count", 64'(o_count), 64'(0));
      tick();
    end
    o_ready = 1'b1;
    sb.push_back(32'd4);
    repeat (4) beat(1, 1);
    idle(3);

    // Test 5: reset mid-group discards partial sum
    beat(9, 9);
    beat(9, 9);
    i_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_o_valid", 64'(o_valid), 64'(0));
    chk("t5_o_count", 64'(o_count), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t5_i_ready", 64'(i_ready), 64'(1));
    sb.push_back(32'd4);
    repeat (4) beat(1, 1);
    idle(3);

    // Test 6: 16-bit accumulator wraps
    chk("t6_ready", 64'(ir2), 64'(1));
    v2 = 1'b1;
    d2 = 16'h8080;
    repeat (4) tick();
    v2 = 1'b0;
    tick();
    chk("t6_wrap_valid", 64'(ov2), 64'(1));
    chk("t6_wrap_data", 64'(od2), 64'(16'h0000));
    v2 = 1'b1;
    d2 = 16'h7F7F;
    repeat (4) tick();
    v2 = 1'b0;
    tick();
    chk("t6_pos_valid", 64'(ov2), 64'(1));
    chk("t6_pos_data", 64'(od2), 64'(16'hFC04));
    chk("t6_count", 64'(oc2), 64'(0));

    for (int n = 0; n < 20 && sb.size() != 0; n++)
      tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("result_count", 64'(results), 64'(7));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
